commit_trace_fifo: RTL and testbench

//  Retirement-trace buffer directly downstream of the core's trace outputs (pc/instr/reg_addr/reg_data/reg_update).

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/commit_trace_fifo_sync_fifo.sv | 81 ++++++++
 rtl/commit_trace_fifo.sv | 130 +++++++++++++
 tb/tb_commit_trace_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core-level definitions.
//   XLEN             architectural register width (32)
//   trace_rec_t      one retirement-trace record {pc, instr, reg_addr, reg_data, reg_update}
//   TRACE_DEPTH_DEF  default entry count of the commit trace buffer
package riscv_pkg;

    localparam int XLEN = 32;

    localparam int TRACE_DEPTH_DEF = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic            reg_update;
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage : riscv_pkg

// File: rtl/commit_trace_fifo_sync_fifo.sv
// sync_fifo: generic single-clock show-ahead FIFO.
// The head entry is always visible on rdata_o. The caller must not assert
// push_i while full_o is high unless pop_i is asserted in the same cycle.
// The storage array is not reset; only the pointers and the occupancy are.
// Ports:
//   clk_i    clock
//   rstn_i   synchronous active-low reset (pointers and count)
//   push_i   write wdata_i at the tail this cycle
//   pop_i    retire the head entry this cycle
//   wdata_i  data to write
//   rdata_o  head entry (meaningful only while empty_o = 0)
//   full_o   count_o == DEPTH
//   empty_o  count_o == 0
//   count_o  occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Occupancy is tracked explicitly instead of being derived from the pointers.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule : sync_fifo

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: retirement-trace buffer fed by the core's trace outputs.
// One record is captured per cycle with trace_valid_i high and streamed out on a
// valid/ready port. The core is never stalled: a record arriving while the buffer
// is full and the head is not being taken is dropped and overflow_o is set (sticky).
// Optional build macro TRACE_DROP_CNT_EN adds a saturating 16-bit dropped-record
// counter on drop_cnt_o; without it drop_cnt_o is constant zero.
// Ports:
//   clk_i, rstn_i      clock, synchronous active-low reset
//   trace_valid_i      capture strobe
//   pc_i, instr_i      committed pc / instruction
//   reg_addr_i         destination register
//   reg_data_i         write-back data
//   reg_update_i       register-write flag (records are kept regardless of it)
//   out_valid_o        buffer non-empty, out_rec_o holds the head
//   out_ready_i        consumer takes the head
//   out_rec_o          head record
//   count_o            occupancy, 0..DEPTH
//   overflow_o         sticky drop flag
//   ovf_clr_i          clears overflow_o and drop_cnt_o
//   drop_cnt_o         dropped-record count
module commit_trace_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     trace_valid_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    input  logic                     reg_update_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output trace_rec_t               out_rec_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i,
    output logic [15:0]              drop_cnt_o
);

    trace_rec_t               wr_rec;
    logic [TRACE_REC_W-1:0]   rd_bits;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     overflow_q, overflow_d;

    assign wr_rec.pc         = pc_i;
    assign wr_rec.instr      = instr_i;
    assign wr_rec.reg_addr   = reg_addr_i;
    assign wr_rec.reg_data   = reg_data_i;
    assign wr_rec.reg_update = reg_update_i;

    // out_valid_o comes straight from registered occupancy, so out_ready_i only
    // reaches the outputs through the pointer/count flops.
    assign pop  = ~fifo_empty & out_ready_i;
    // A full buffer still accepts a record when the head leaves in the same cycle.
    assign push = trace_valid_i & (~fifo_full | pop);
    assign drop = trace_valid_i & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (rd_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign out_valid_o = ~fifo_empty;
    assign out_rec_o   = trace_rec_t'(rd_bits);

    // A drop coinciding with a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Clear and drop together restart the count at one: the clear discards the
    // old history and the coincident drop is the first of the new one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr_i) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = 16'h0000;
`endif

endmodule : commit_trace_fifo

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic            trace_valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic [4:0]      reg_addr_i;
    logic [XLEN-1:0] reg_data_i;
    logic            reg_update_i;
    logic            out_valid_o;
    logic            out_ready_i;
    trace_rec_t      out_rec_o;
    logic [CW-1:0]   count_o;
    logic            overflow_o;
    logic            ovf_clr_i;
    logic [15:0]     drop_cnt_o;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .trace_valid_i (trace_valid_i),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .reg_addr_i    (reg_addr_i),
        .reg_data_i    (reg_data_i),
        .reg_update_i  (reg_update_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_rec_o     (out_rec_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .ovf_clr_i     (ovf_clr_i),
        .drop_cnt_o    (drop_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    trace_rec_t exp_q [$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        clr;
        int          exp_count;
        logic        exp_ovf;
        int          exp_drop;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic trace_rec_t mk(input logic [31:0] pc);
        trace_rec_t r;
        r.pc         = pc;
        r.instr      = pc ^ 32'h0000_0013;
        r.reg_addr   = pc[6:2];
        r.reg_data   = ~pc;
        r.reg_update = pc[2];
        return r;
    endfunction

    // One cycle: drive at negedge, score the head if taken, predict acceptance,
    // then look at the registered outputs 1 time unit after the edge.
    task automatic step(input logic v, input trace_rec_t rec, input logic rdy, input logic clr);
        logic popped;
        @(negedge clk);
        trace_valid_i = v;
        pc_i          = rec.pc;
        instr_i       = rec.instr;
        reg_addr_i    = rec.reg_addr;
        reg_data_i    = rec.reg_data;
        reg_update_i  = rec.reg_update;
        out_ready_i   = rdy;
        ovf_clr_i     = clr;
        #1;
        popped = 1'b0;
        if (out_valid_o && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 1'b1, 1'b0);
            end else begin
                chk("head_rec", out_rec_o, exp_q.pop_front());
                popped = 1'b1;
            end
        end
        if (v && ((exp_q.size() + (popped ? 1 : 0)) < DEPTH || popped)) begin
            exp_q.push_back(rec);
        end
        @(posedge clk);
        #1;
        chk("valid_vs_model", out_valid_o, exp_q.size() != 0);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, mk(vecs[i].pc), vecs[i].rdy, vecs[i].clr);
            chk($sformatf("count[%0d]", i), count_o, vecs[i].exp_count);
            chk($sformatf("ovf[%0d]", i), overflow_o, vecs[i].exp_ovf);
`ifdef TRACE_DROP_CNT_EN
            chk($sformatf("drop[%0d]", i), drop_cnt_o, vecs[i].exp_drop);
`else
            chk($sformatf("drop[%0d]", i), drop_cnt_o, 0);
`endif
        end
        vecs.delete();
    endtask

    initial begin
        trace_rec_t r;
        rstn_i        = 1'b0;
        trace_valid_i = 1'b1;
        pc_i          = 32'hDEAD_BEEF;
        instr_i       = '0;
        reg_addr_i    = '0;
        reg_data_i    = '0;
        reg_update_i  = 1'b1;
        out_ready_i   = 1'b0;
        ovf_clr_i     = 1'b0;

        // Reset held two cycles while the core strobes records.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_count", count_o, 0);
        @(negedge clk);
        rstn_i        = 1'b1;
        trace_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid_o, 1'b0);
        chk("post_rst_count", count_o, 0);
        chk("post_rst_ovf", overflow_o, 1'b0);
        chk("post_rst_drop", drop_cnt_o, 0);

        // Single push and a one-cycle ready pulse.
        r.pc = 32'h8000_0000; r.instr = 32'h0010_0093; r.reg_addr = 5'd1;
        r.reg_data = 32'h1; r.reg_update = 1'b1;
        step(1'b1, r, 1'b0, 1'b0);
        chk("single_valid", out_valid_o, 1'b1);
        chk("single_rec", out_rec_o, r);
        chk("single_count", count_o, 1);
        step(1'b0, r, 1'b1, 1'b0);
        chk("single_drain_count", count_o, 0);

        // Fill, drop, full+push+pop, drain.
        vecs.push_back('{1, 32'h00, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 32'h04, 0, 0, 2, 0, 0});
        vecs.push_back('{1, 32'h08, 0, 0, 3, 0, 0});
        vecs.push_back('{1, 32'h0C, 0, 0, 4, 0, 0});
        vecs.push_back('{1, 32'h10, 0, 0, 4, 1, 1});
        vecs.push_back('{1, 32'h14, 1, 0, 4, 1, 1});
        vecs.push_back('{0, 32'h00, 1, 0, 3, 1, 1});
        vecs.push_back('{0, 32'h00, 1, 0, 2, 1, 1});
        vecs.push_back('{0, 32'h00, 1, 0, 1, 1, 1});
        vecs.push_back('{0, 32'h00, 1, 0, 0, 1, 1});
        // Refill; clear coinciding with a drop, then a lone clear, then drain.
        vecs.push_back('{1, 32'h20, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 32'h24, 0, 0, 2, 1, 1});
        vecs.push_back('{1, 32'h28, 0, 0, 3, 1, 1});
        vecs.push_back('{1, 32'h2C, 0, 0, 4, 1, 1});
        vecs.push_back('{1, 32'h30, 0, 0, 4, 1, 2});
        vecs.push_back('{1, 32'h34, 0, 1, 4, 1, 1});
        vecs.push_back('{0, 32'h00, 0, 1, 4, 0, 0});
        vecs.push_back('{0, 32'h00, 1, 0, 3, 0, 0});
        vecs.push_back('{0, 32'h00, 1, 0, 2, 0, 0});
        vecs.push_back('{0, 32'h00, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 32'h00, 1, 0, 0, 0, 0});
        run_vecs();

        // Streaming with ready held high: pointers wrap five times.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, mk(32'h100 + 32'(4 * i)), 1'b1, 1'b0);
            chk($sformatf("stream_count[%0d]", i), count_o <= 1, 1'b1);
        end
        step(1'b0, mk(32'h0), 1'b1, 1'b0);
        chk("stream_end_count", count_o, 0);
        chk("stream_sb_empty", exp_q.size(), 0);
        chk("stream_ovf", overflow_o, 1'b0);

        // Reset mid-stream discards buffered records.
        step(1'b1, mk(32'h200), 1'b0, 1'b0);
        step(1'b1, mk(32'h204), 1'b0, 1'b0);
        @(negedge clk);
        rstn_i = 1'b0;
        trace_valid_i = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", out_valid_o, 1'b0);
        @(negedge clk);
        rstn_i = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_commit_trace_fifo
